// File: rtl/xpmwrap_arb_pkg.sv
// ---------------------------------------------------------------------------
// xpmwrap_arb_pkg
//   Shared types, constants and the round-robin pick function used by the
//   FIFO write-port arbiter (xpmwrap_fifo_wr_arb) and its round-robin
//   sub-module (xpmwrap_rr_arbiter).
//
//   arb_state_e : arbiter FSM state encoding
//   STAT_W      : width of each per-requester beat counter
//                 (XPMWRAP_ARB_STATS_EN builds only)
//   rr_pick()   : first set bit of 'valid' at or after 'ptr', wrapping
//                 modulo num_req
// ---------------------------------------------------------------------------
package xpmwrap_arb_pkg;

  typedef enum logic [1:0] {
    RST_HOLD = 2'd0,
    RST_WAIT = 2'd1,
    IDLE     = 2'd2,
    XFER     = 2'd3
  } arb_state_e;

  localparam int STAT_W   = 16;
  localparam int MAX_REQ  = 8;
  localparam int MAX_ID_W = 3;
  localparam int IDX_W    = MAX_ID_W + 1;

  // Searches ptr, ptr+1, ... modulo num_req. The index is one bit wider
  // than an id so that ptr+k cannot overflow before it is wrapped.
  // Returns 0 if nothing is valid; the caller qualifies the result with
  // an OR-reduction of the request vector.
  function automatic logic [MAX_ID_W-1:0] rr_pick(
    input logic [MAX_REQ-1:0]  valid,
    input logic [MAX_ID_W-1:0] ptr,
    input int                  num_req
  );
    logic [MAX_ID_W-1:0] win;
    logic                found;
    logic [IDX_W-1:0]    idx;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = {1'b0, ptr} + IDX_W'(k);
      if (idx >= IDX_W'(num_req)) idx = idx - IDX_W'(num_req);
      if ((k < num_req) && !found && valid[idx[MAX_ID_W-1:0]]) begin
        win   = idx[MAX_ID_W-1:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/xpmwrap_rr_arbiter.sv
// ---------------------------------------------------------------------------
// xpmwrap_rr_arbiter
//   Combinational round-robin pick over a request vector, plus the
//   registered round-robin pointer. On 'upd' the pointer moves to
//   upd_idx+1 (wrapping), so the requester just served gets the lowest
//   priority.
//
// Ports
//   clk, rst_n : clock, asynchronous active-low reset (pointer -> 0)
//   req        : eligible requesters
//   upd        : pointer update strobe
//   upd_idx    : index that was just served
//   pick_idx   : winner for the current pointer
//   pick_vld   : at least one requester is eligible
// ---------------------------------------------------------------------------
module xpmwrap_rr_arbiter
  import xpmwrap_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               upd,
  input  logic [ID_W-1:0]    upd_idx,
  output logic [ID_W-1:0]    pick_idx,
  output logic               pick_vld
);

  logic [ID_W-1:0] rr_ptr;

  assign pick_idx = ID_W'(rr_pick(MAX_REQ'(req), MAX_ID_W'(rr_ptr), NUM_REQ));
  assign pick_vld = |req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (upd) begin
      rr_ptr <= (upd_idx == ID_W'(NUM_REQ - 1)) ? '0 : upd_idx + ID_W'(1);
    end
  end

endmodule

// File: rtl/xpmwrap_fifo_wr_arb.sv
// ---------------------------------------------------------------------------
// xpmwrap_fifo_wr_arb
//   Round-robin arbiter sharing the write port of one xpmwrap_fifo_sync
//   among NUM_REQ valid/ready producers, all in the wr_clk domain. After
//   reset it pulses fifo_rst for RST_CYCLES cycles and waits for the FIFO
//   to leave wr_rst_busy before granting anyone. With PKT_MODE=1 a grant
//   is held until the beat carrying req_last is accepted.
//
// Optional build macro
//   XPMWRAP_ARB_STATS_EN : adds stat_beats, one saturating 16-bit
//                          accepted-beat counter per requester.
//
// Ports
//   wr_clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/ready/last   : per-requester handshake and packet end
//   req_data               : requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   fifo_rst, fifo_wr_en,
//   fifo_din               : to the FIFO write side
//   fifo_full, fifo_prog_full,
//   fifo_wr_rst_busy       : from the FIFO write side
//   grant_id, grant_vld    : current grant (grant_vld high in XFER)
//   init_done              : FIFO reset sequence complete
//   stat_beats             : per-requester beat counters (stats build)
//
// State table
//   state    | meaning
//   RST_HOLD | fifo_rst high, counting RST_CYCLES
//   RST_WAIT | fifo_rst low, waiting (>=2 cycles) for wr_rst_busy to clear
//   IDLE     | arbitrating among eligible requesters (1-cycle bubble)
//   XFER     | grant_id owns the FIFO write port
// ---------------------------------------------------------------------------
module xpmwrap_fifo_wr_arb
  import xpmwrap_arb_pkg::*;
#(
  parameter  int NUM_REQ            = 4,
  parameter  int DATA_WIDTH         = 32,
  parameter  int PKT_MODE           = 1,
  parameter  int RST_CYCLES         = 4,
  parameter  int THROTTLE_PROG_FULL = 1,
  localparam int ID_W               = $clog2(NUM_REQ)
) (
  input  logic                          wr_clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic                          fifo_rst,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  input  logic                          fifo_full,
  input  logic                          fifo_prog_full,
  input  logic                          fifo_wr_rst_busy,
  output logic [ID_W-1:0]               grant_id,
  output logic                          grant_vld,
  output logic                          init_done
`ifdef XPMWRAP_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0]     stat_beats
`endif
);

  arb_state_e            state;
  logic [3:0]            rst_cnt;
  logic                  wait_min;
  logic [DATA_WIDTH-1:0] din_q;
  logic [DATA_WIDTH-1:0] gnt_data;
  logic [NUM_REQ-1:0]    elig;
  logic [ID_W-1:0]       pick_idx;
  logic                  pick_vld;
  logic                  pkt_end;
  logic                  rr_upd;
  logic                  port_open;

  // prog_full only gates new grants; an ongoing grant is never broken by it.
  assign elig = ((THROTTLE_PROG_FULL != 0) && fifo_prog_full) ? '0 : req_valid;

  assign gnt_data = req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];

  // Ready is gated by the same terms as wr_en so a producer never sees a
  // beat accepted that the FIFO did not take.
  assign port_open = (state == XFER) && !fifo_full && !fifo_wr_rst_busy && !fifo_rst;

  always_comb begin
    req_ready = '0;
    if (port_open) req_ready[grant_id] = 1'b1;
  end

  assign fifo_wr_en = port_open && req_valid[grant_id];
  // Zero-latency data path that holds the last written word between writes.
  assign fifo_din   = fifo_wr_en ? gnt_data : din_q;

  assign pkt_end = (PKT_MODE == 0) || req_last[grant_id];
  assign rr_upd  = fifo_wr_en && pkt_end;

  xpmwrap_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .clk      (wr_clk),
    .rst_n    (rst_n),
    .req      (elig),
    .upd      (rr_upd),
    .upd_idx  (grant_id),
    .pick_idx (pick_idx),
    .pick_vld (pick_vld)
  );

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RST_HOLD;
      fifo_rst  <= 1'b1;
      rst_cnt   <= '0;
      wait_min  <= 1'b0;
      grant_id  <= '0;
      grant_vld <= 1'b0;
      init_done <= 1'b0;
      din_q     <= '0;
    end else begin
      if (fifo_wr_en) din_q <= gnt_data;
      case (state)
        RST_HOLD: begin
          if (rst_cnt == 4'(RST_CYCLES - 1)) begin
            fifo_rst <= 1'b0;
            wait_min <= 1'b0;
            state    <= RST_WAIT;
          end else begin
            rst_cnt <= rst_cnt + 4'd1;
          end
        end
        RST_WAIT: begin
          // wait_min marks that the first RST_WAIT cycle has elapsed.
          if (wait_min && !fifo_wr_rst_busy) begin
            init_done <= 1'b1;
            state     <= IDLE;
          end else begin
            wait_min <= 1'b1;
          end
        end
        IDLE: begin
          if (fifo_wr_rst_busy) begin
            init_done <= 1'b0;
            wait_min  <= 1'b0;
            state     <= RST_WAIT;
          end else if (pick_vld) begin
            grant_id  <= pick_idx;
            grant_vld <= 1'b1;
            state     <= XFER;
          end
        end
        XFER: begin
          if (fifo_wr_rst_busy) begin
            init_done <= 1'b0;
            grant_vld <= 1'b0;
            wait_min  <= 1'b0;
            state     <= RST_WAIT;
          end else if (rr_upd) begin
            grant_vld <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= RST_HOLD;
      endcase
    end
  end

`ifdef XPMWRAP_ARB_STATS_EN
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    logic [STAT_W-1:0] beats_q;

    always_ff @(posedge wr_clk or negedge rst_n) begin
      if (!rst_n) begin
        beats_q <= '0;
      end else if (fifo_wr_en && (grant_id == ID_W'(g)) && (beats_q != '1)) begin
        beats_q <= beats_q + STAT_W'(1);
      end
    end

    assign stat_beats[g*STAT_W +: STAT_W] = beats_q;
  end
`endif

endmodule
